// File: rtl/csr_counter_if.sv
// CSR access bus between the decode/writeback stage and the counter CSR block.
// Signal suffixes are named from the counter block's side of the bus.
interface csr_counter_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr_i;
  logic            csr_re_i;
  logic            csr_we_i;
  logic [1:0]      csr_op_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  modport master (
    output csr_addr_i, csr_re_i, csr_we_i, csr_op_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_addr_i, csr_re_i, csr_we_i, csr_op_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_counter_unit.sv
// Performance-counter CSR block: mcycle, minstret, NUM_HPM mhpmcounters and
// mcountinhibit, with machine-mode read/write and user-mode read-only shadows.
module csr_counter_unit #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_HPM   = 4,
  localparam int HE_W     = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_counter_if.slave    bus,
  input  logic            retire_i,
  input  logic [HE_W-1:0] hpm_event_i
);

  // Counter slots: 0 = cycle, 1 = instret, 2+k = hpm counter 3+k.
  localparam int NC   = NUM_HPM + 2;
  localparam int HI_W = CNT_WIDTH - 32;
  localparam int IW   = NUM_HPM + 3;
  // Bit 1 of mcountinhibit (the time counter) does not exist here.
  localparam logic [IW-1:0] INH_MASK = ~IW'(2);

  logic [CNT_WIDTH-1:0] cnt_q [NC];
  logic [CNT_WIDTH-1:0] cnt_d [NC];
  logic [IW-1:0]        inh_q, inh_d;

  logic            is_cnt_blk, is_user, is_hi, is_inh, impl, wr_en;
  logic [NC-1:0]   sel, inc;
  logic [XLEN-1:0] sel_val, new_val;

  // Address offset within the 0xB00/0xC00 block for each counter slot.
  function automatic logic [4:0] cnt_off(input int i);
    return 5'((i == 0) ? 0 : ((i == 1) ? 2 : i + 1));
  endfunction

  // CSRRW / CSRRS / CSRRC read-modify-write of one 32-bit half.
  function automatic logic [XLEN-1:0] csr_apply(input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] wd,
                                                input logic [1:0]      op);
    case (op)
      2'b01:   return wd;
      2'b10:   return old | wd;
      2'b11:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  assign is_cnt_blk = ((bus.csr_addr_i[11:8] == 4'hB) || (bus.csr_addr_i[11:8] == 4'hC))
                      && (bus.csr_addr_i[6:5] == 2'b00);
  assign is_user    = (bus.csr_addr_i[11:8] == 4'hC);
  assign is_hi      = bus.csr_addr_i[7];
  assign is_inh     = (bus.csr_addr_i == 12'h320);

  // Decode which counter (if any) the address names.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NC; i++)
      sel[i] = is_cnt_blk && (bus.csr_addr_i[4:0] == cnt_off(i));
  end

  assign impl  = is_inh | (|sel);
  assign wr_en = bus.csr_we_i & (bus.csr_op_i != 2'b00) & impl & ~is_user;

  assign bus.csr_illegal_o = (bus.csr_re_i | bus.csr_we_i) &
                             (~impl | (bus.csr_we_i & (bus.csr_op_i != 2'b00) & is_user));

  // Current value of the addressed half; feeds both the read port and the RMW.
  always_comb begin
    sel_val = '0;
    if (is_inh) sel_val = XLEN'(inh_q);
    for (int i = 0; i < NC; i++)
      if (sel[i]) sel_val = is_hi ? XLEN'(cnt_q[i][CNT_WIDTH-1:32]) : cnt_q[i][31:0];
  end

  assign new_val         = csr_apply(sel_val, bus.csr_wdata_i, bus.csr_op_i);
  assign bus.csr_rdata_o = (bus.csr_re_i && !bus.csr_illegal_o) ? sel_val : '0;

  // Per-counter increment enables, gated by the current inhibit bits.
  always_comb begin
    inc    = '0;
    inc[0] = ~inh_q[0];
    inc[1] = retire_i & ~inh_q[2];
    for (int k = 0; k < NUM_HPM; k++)
      inc[2+k] = hpm_event_i[k] & ~inh_q[3+k];
  end

  // Next counter values: a low-half write suppresses the increment, a
  // high-half write keeps the low increment but drops its carry.
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_WIDTH'(inc[i]);
      if (wr_en && sel[i]) begin
        if (is_hi) cnt_d[i] = {new_val[HI_W-1:0], cnt_q[i][31:0] + 32'(inc[i])};
        else       cnt_d[i] = {cnt_q[i][CNT_WIDTH-1:32], new_val};
      end
    end
  end

  // Next inhibit value; the hardwired-zero bits are masked off.
  always_comb begin
    inh_d = inh_q;
    if (wr_en && is_inh) inh_d = new_val[IW-1:0] & INH_MASK;
  end

  // Counter and inhibit state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
      inh_q <= '0;
    end else begin
      for (int i = 0; i < NC; i++) cnt_q[i] <= cnt_d[i];
      inh_q <= inh_d;
    end
  end

endmodule
